// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store at a time, stalls the pipeline for LATENCY cycles
// and signals completion with a one-cycle valid_o pulse.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        valid_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;

  logic               lat_we;
  logic               lat_mis;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_wdata;

  logic               req_c;
  logic               mis_in_c;
  logic               acc_we_c;
  logic               acc_mis_c;
  logic [IDX_W-1:0]   acc_idx_c;
  logic [31:0]        acc_wdata_c;
  logic               commit_c;
  logic               mem_we_c;
  logic               unused_addr_c;

  logic [31:0]        mem [DEPTH];

  assign req_c = MemRead_i | MemWrite_i;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_in_c = (addr_i[1:0] != 2'b00);
`else
  assign mis_in_c = 1'b0;
`endif

  // Upper address bits wrap; low bits only matter when the trap is enabled.
  assign unused_addr_c = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  // In IDLE the live inputs describe the access; afterwards the latched copy.
  always_comb begin
    acc_we_c    = lat_we;
    acc_mis_c   = lat_mis;
    acc_idx_c   = lat_idx;
    acc_wdata_c = lat_wdata;
    if (state == ST_IDLE) begin
      acc_we_c    = MemWrite_i;
      acc_mis_c   = mis_in_c;
      acc_idx_c   = addr_i[IDX_W+1:2];
      acc_wdata_c = data_i;
    end
  end

  // Completion edge: the edge that moves the FSM into DONE.
  always_comb begin
    commit_c = 1'b0;
    case (state)
      ST_IDLE: commit_c = req_c && (LATENCY == 32'd1);
      ST_WAIT: commit_c = (cnt == CNT_W'(1));
      default: commit_c = 1'b0;
    endcase
  end

  assign mem_we_c = commit_c & acc_we_c & ~acc_mis_c & ~rst_i;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE always returns to IDLE so a held request is not re-taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_c) begin
          state_nxt = (LATENCY == 32'd1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stall: request-driven in IDLE, forced while counting, released in DONE and reset.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      ST_IDLE: stall_o = req_c & ~rst_i;
      ST_WAIT: stall_o = ~rst_i;
      default: stall_o = 1'b0;
    endcase
  end

  // Request latch, latency counter and registered completion outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_mis   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      valid_o <= commit_c;
      err_o   <= commit_c & acc_mis_c;
      if ((state == ST_IDLE) && req_c) begin
        lat_we    <= MemWrite_i;
        lat_mis   <= mis_in_c;
        lat_idx   <= addr_i[IDX_W+1:2];
        lat_wdata <= data_i;
        cnt       <= CNT_W'(LATENCY - 1);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit_c && !acc_we_c && !acc_mis_c) begin
        data_o <= mem[acc_idx_c];
      end
    end
  end

  // Storage array; never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      mem[acc_idx_c] <= acc_wdata_c;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (DEPTH=32, LATENCY=3).
module tb_dmem_responder;

  localparam int unsigned LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        valid_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(.DEPTH(32), .LATENCY(LAT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check_word(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %b required %b", nm, act, exp);
    end
  endtask

  // Call just after a rising edge; returns just after the DONE->IDLE edge
  // with the request still driven (CPU holds it until stall drops).
  task automatic run_acc(input string nm, input logic re, input logic we,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_data, input logic exp_err);
    MemRead_i  = re;
    MemWrite_i = we;
    addr_i     = a;
    data_i     = d;
    for (int c = 0; c < int'(LAT); c++) begin
      @(negedge clk_i);
      check_bit({nm, " stall"}, stall_o, 1'b1);
      check_bit({nm, " early valid"}, valid_o, 1'b0);
    end
    @(negedge clk_i);
    check_bit({nm, " valid"}, valid_o, 1'b1);
    check_bit({nm, " done stall"}, stall_o, 1'b0);
    check_bit({nm, " err"}, err_o, exp_err);
    check_word({nm, " data"}, data_o, exp_data);
    @(posedge clk_i);
    #1;
  endtask

  task automatic go_idle(input string nm, input logic [31:0] exp_data);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    check_bit({nm, " idle stall"}, stall_o, 1'b0);
    check_bit({nm, " idle valid"}, valid_o, 1'b0);
    check_word({nm, " idle data"}, data_o, exp_data);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    logic        mis_err;
    logic [31:0] mis_word;

`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err  = 1'b1;
    mis_word = 32'h1111_1111;
`else
    mis_err  = 1'b0;
    mis_word = 32'h7777_7777;
`endif

    vecs[0] = '{re: 1'b0, we: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, rdata: 32'h0};
    vecs[1] = '{re: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0,         rdata: 32'hDEAD_BEEF};
    vecs[2] = '{re: 1'b1, we: 1'b1, addr: 32'h08, wdata: 32'h1234,      rdata: 32'h0};
    vecs[3] = '{re: 1'b1, we: 1'b0, addr: 32'h08, wdata: 32'h0,         rdata: 32'h1234};
    vecs[4] = '{re: 1'b0, we: 1'b1, addr: 32'h84, wdata: 32'hA5A5_A5A5, rdata: 32'h0};
    vecs[5] = '{re: 1'b1, we: 1'b0, addr: 32'h04, wdata: 32'h0,         rdata: 32'hA5A5_A5A5};
    vecs[6] = '{re: 1'b0, we: 1'b1, addr: 32'h0C, wdata: 32'h1111_1111, rdata: 32'h0};
    vecs[7] = '{re: 1'b1, we: 1'b0, addr: 32'h0C, wdata: 32'h0,         rdata: 32'h1111_1111};
    vecs[8] = '{re: 1'b0, we: 1'b1, addr: 32'h7C, wdata: 32'hCAFE_F00D, rdata: 32'h0};
    vecs[9] = '{re: 1'b1, we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0,  rdata: 32'hCAFE_F00D};

    rst_i      = 1'b0;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    addr_i     = '0;
    data_i     = '0;
    #1 rst_i   = 1'b1;
    #12;
    check_word("reset data", data_o, 32'h0);
    check_bit("reset stall", stall_o, 1'b0);
    check_bit("reset valid", valid_o, 1'b0);
    check_bit("reset err", err_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Back-to-back accesses, each request held through its stall.
    held = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].re && !vecs[i].we) held = vecs[i].rdata;
      run_acc($sformatf("vec%0d", i), vecs[i].re, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, held, 1'b0);
    end
    go_idle("after table", held);

    // Reset in the middle of a store's WAIT phase discards the store.
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b1;
    addr_i     = 32'h0C;
    data_i     = 32'h55;
    @(negedge clk_i);
    check_bit("rst seq stall T", stall_o, 1'b1);
    @(negedge clk_i);
    check_bit("rst seq stall T+1", stall_o, 1'b1);
    rst_i      = 1'b1;
    MemWrite_i = 1'b0;
    #1;
    check_bit("rst seq stall", stall_o, 1'b0);
    check_bit("rst seq valid", valid_o, 1'b0);
    check_word("rst seq data", data_o, 32'h0);
    @(posedge clk_i);
    #1;
    check_bit("rst seq held stall", stall_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    held = 32'h1111_1111;
    run_acc("rst seq load", 1'b1, 1'b0, 32'h0C, 32'h0, held, 1'b0);
    go_idle("rst seq", held);

    // Misaligned store: trapped and dropped with the feature, else a plain store.
    run_acc("mis store", 1'b0, 1'b1, 32'h0E, 32'h7777_7777, held, mis_err);
    go_idle("mis store", held);
    held = mis_word;
    run_acc("mis load", 1'b1, 1'b0, 32'h0C, 32'h0, held, 1'b0);
    go_idle("mis load", held);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
